// File: rtl/amstrad_tape_player.sv
`default_nettype none
// ============================================================================
// Module      : amstrad_tape_player
// Description : CSW v1 RLE tape image player. It prefetches image bytes into a
//               small FIFO and regenerates the cassette read level.
// Revision    : 1.0 - initial release
// ============================================================================
module amstrad_tape_player #(
  parameter int FIFO_DEPTH = 4,
  parameter bit INIT_LEVEL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_ce,
  input  logic        start,
  input  logic        tape_motor,
  input  logic [24:0] data_size,
  output logic [24:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [7:0]  mem_din,
  output logic        tape_in,
  output logic        playing,
  output logic        eof
);

  localparam int            c_AW    = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0] c_DEPTH = (c_AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_LOAD  = 3'd1;
  localparam logic [2:0] c_EXT0  = 3'd2;
  localparam logic [2:0] c_EXT1  = 3'd3;
  localparam logic [2:0] c_EXT2  = 3'd4;
  localparam logic [2:0] c_EXT3  = 3'd5;
  localparam logic [2:0] c_COUNT = 3'd6;

  logic [7:0]      r_fifo [FIFO_DEPTH];
  logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic            r_discard;
  logic [2:0]      r_state, w_state_next;
  logic [31:0]     r_cnt;
  logic [7:0]      w_head;
  logic            w_empty, w_at_end, w_tick, w_push, w_issue;
  logic            w_pop, w_take_eof, w_toggle;

  assign w_empty  = (r_count == '0);
  assign w_head   = r_fifo[r_rd_ptr];
  assign w_tick   = sample_ce & tape_motor;
  assign w_push   = mem_rd & mem_ack & ~r_discard & ~start;
  assign w_at_end = (mem_addr == data_size) & w_empty & ~mem_rd;
  // The slot of an outstanding read is already reserved because mem_rd must be low to issue.
  assign w_issue  = playing & ~mem_rd & ~start & (r_count < c_DEPTH) & (mem_addr < data_size);

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= mem_din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (start) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // A read still in flight across a start is allowed to finish, but its byte is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      r_discard <= 1'b0;
    end else begin
      if (mem_rd && mem_ack) begin
        mem_rd    <= 1'b0;
        r_discard <= 1'b0;
        if (!r_discard && !start) mem_addr <= mem_addr + 25'd1;
      end else if (w_issue) begin
        mem_rd <= 1'b1;
      end
      if (start) begin
        mem_addr  <= '0;
        r_discard <= mem_rd & ~mem_ack;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_LOAD: begin
        if (!w_empty)      w_state_next = (w_head == 8'd0) ? c_EXT0 : c_COUNT;
        else if (w_at_end) w_state_next = c_IDLE;
      end
      c_EXT0: begin
        if (!w_empty)      w_state_next = c_EXT1;
        else if (w_at_end) w_state_next = c_IDLE;
      end
      c_EXT1: begin
        if (!w_empty)      w_state_next = c_EXT2;
        else if (w_at_end) w_state_next = c_IDLE;
      end
      c_EXT2: begin
        if (!w_empty)      w_state_next = c_EXT3;
        else if (w_at_end) w_state_next = c_IDLE;
      end
      c_EXT3: begin
        if (!w_empty)      w_state_next = ({w_head, r_cnt[23:0]} != 32'd0) ? c_COUNT : c_LOAD;
        else if (w_at_end) w_state_next = c_IDLE;
      end
      c_COUNT: begin
        if (w_tick && r_cnt == 32'd1) w_state_next = c_LOAD;
      end
      default: ;
    endcase
    if (start) w_state_next = c_LOAD;
  end

  always_comb begin
    w_pop      = 1'b0;
    w_take_eof = 1'b0;
    w_toggle   = 1'b0;
    if (!start) begin
      case (r_state)
        c_LOAD, c_EXT0, c_EXT1, c_EXT2, c_EXT3: begin
          w_pop      = ~w_empty;
          w_take_eof = w_at_end;
        end
        c_COUNT: w_toggle = w_tick & (r_cnt == 32'd1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      tape_in <= INIT_LEVEL;
      playing <= 1'b0;
      eof     <= 1'b0;
    end else if (start) begin
      tape_in <= INIT_LEVEL;
      playing <= 1'b1;
      eof     <= 1'b0;
    end else begin
      if (w_pop) begin
        case (r_state)
          c_LOAD:  r_cnt <= {24'd0, w_head};
          c_EXT0:  r_cnt[7:0]   <= w_head;
          c_EXT1:  r_cnt[15:8]  <= w_head;
          c_EXT2:  r_cnt[23:16] <= w_head;
          c_EXT3:  r_cnt[31:24] <= w_head;
          default: ;
        endcase
      end else if (r_state == c_COUNT && w_tick) begin
        r_cnt <= r_cnt - 32'd1;
      end
      if (w_toggle) tape_in <= ~tape_in;
      if (w_take_eof) begin
        playing <= 1'b0;
        eof     <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/amstrad_tape_player.md
# amstrad_tape_player

Streams a CSW v1 RLE tape image from external memory and regenerates the cassette read signal for the Amstrad motherboard's `tape_in` input. It sits directly upstream of the motherboard:
- it fetches image bytes through a simple request/acknowledge port;
- it buffers them in a small prefetch FIFO;
- it decodes pulse lengths and toggles `tape_in` at the sample rate while the PPI-driven `tape_motor` is on.

## Interface
Parameters:
- FIFO_DEPTH, 4, prefetch FIFO entries (power of two, ≥2).
- INIT_LEVEL, 0, `tape_in` level after reset/start.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_ce  in  1  one-cycle enable at the CSW sample rate; generated elsewhere.
- start  in  1  one-cycle pulse: rewind to image offset 0, flush, begin playback.
- tape_motor  in  1  motor control from the motherboard; 0 freezes pulse timing.
- data_size  in  25  image payload length in bytes (header already stripped).
- mem_addr  out  25  byte address of the current fetch.
- mem_rd  out  1  fetch request, level; held until acknowledged.
- mem_ack  in  1  one-cycle acknowledge; mem_din valid in the same cycle.
- mem_din  in  8  fetched byte.
- tape_in  out  1  regenerated cassette level to the motherboard.
- playing  out  1  decoder active (started, not at EOF).
- eof  out  1  image exhausted and last pulse finished.

## Operation
- **Reset values:** mem_addr=0, mem_rd=0, tape_in=INIT_LEVEL, playing=0, eof=0, FIFO empty, decoder IDLE.

**Fetch engine**
- Issues mem_rd when all hold: playing=1, FIFO not full (counting a pending slot), and mem_addr < data_size.
- On mem_ack: pushes mem_din, increments mem_addr, drops mem_rd for at least one cycle.
- Fetching continues regardless of tape_motor.

**Decoder FSM.** All counting and toggling advances only on cycles with sample_ce=1 and tape_motor=1. States:
- IDLE → LOAD on start.
- LOAD pops a byte:
  - nonzero byte N → COUNT with cnt=N.
  - byte 0 → EXT0.
- EXT0..EXT3 pop four bytes, little-endian, into a 32-bit cnt.
  - Then COUNT if cnt≠0.
  - If cnt=0 the extended pulse is ignored: no toggle, back to LOAD.
- COUNT: cnt decrements once per qualified tick. When cnt reaches 0, tape_in toggles on that same tick and the FSM goes to LOAD.
- LOAD/EXTn with an empty FIFO wait (underrun):
  - tape_in holds;
  - no toggle is added or lost;
  - decoding resumes on the cycle after the byte arrives.
- EOF is reached in LOAD when mem_addr = data_size, the FIFO is empty and no read is pending. Then:
  - eof=1 and playing=0;
  - tape_in holds its last level;
  - the FSM goes to IDLE.
- A truncated extended header at EOF (fewer than 4 bytes left) discards the partial length and takes EOF.

**Start mid-operation.** A start pulse in any state:
- flushes the FIFO and resets mem_addr to 0;
- sets tape_in=INIT_LEVEL, eof=0, playing=1;
- sends the FSM to LOAD.

If a read is outstanding at start:
- mem_rd stays high until its ack;
- the acked byte is discarded, not pushed;
- mem_addr stays 0;
- the next request issues for address 0.

**data_size=0.** start leads to eof=1 one cycle after LOAD is entered.

**Simultaneous events**
- FIFO push and pop in the same cycle are both honoured; the count is unchanged.
- reset dominates start.

## Timing
- Fetch: mem_rd rises at least one cycle after the request conditions become true. The ack cycle pushes the byte; mem_rd is 0 in the next cycle.
- Pop-to-COUNT: 1 clk after LOAD sees a non-empty FIFO.
- Pulse width: a byte N yields exactly N qualified sample_ce ticks between consecutive tape_in toggles, provided the FIFO does not underrun.
- LOAD/EXT processing consumes clk cycles, not ticks. The sample_ce spacing must be ≥6 clk for gap-free playback.
- tape_motor 0→1 resumes counting at the first tick after the transition; the remaining cnt is preserved.

## Test plan
- Image {3,5,2}, data_size=3, motor=1, sample_ce every 8 clk, INIT_LEVEL=0 → tape_in high after 3 ticks, low after 5 more, high after 2 more. Then eof=1, playing=0, tape_in=1.
- Image {0,0x10,0x01,0,0, 4} → first toggle after 272 ticks, the next after 4.
- Extended zero {0,0,0,0,0,7} → no toggle for the zero pulse; the first toggle occurs after 7 ticks.
- mem_ack delayed 20 clk per byte, ticks every 8 clk → underrun stalls with tape_in steady. After the ack, decoding resumes and pulse counts stay exact.
- Motor dropped for 50 ticks midway through a 10-tick pulse → tape_in frozen. After the motor returns, the toggle lands after the remaining ticks.
- start asserted while mem_rd is pending at address 2 → the acked byte is discarded, mem_addr=0, the next fetch is address 0, tape_in=INIT_LEVEL, eof=0.
